// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdState_t;

  // MULT and DIV are the signed variants
  function automatic logic isSignedOp(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute/Decode-side signal bundle of the multiply/divide unit.
interface muldiv_ctrl_if #(parameter int unsigned XLEN = muldiv_pkg::XLEN_DEF);

  logic            startE;
  logic [1:0]      opE;
  logic [XLEN-1:0] srcaE;
  logic [XLEN-1:0] srcbE;
  logic [1:0]      hiloweE;
  logic            hiloreadD;
  logic            muldivD;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            stall_md;

  modport master (
    output startE, opE, srcaE, srcbE, hiloweE, hiloreadD, muldivD,
    input  hi, lo, busy, stall_md
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hiloweE, hiloreadD, muldivD,
    output hi, lo, busy, stall_md
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Multiply/divide working registers, one-bit step logic and the HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: flag a multiply done once no multiplier bits remain.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [1:0]      hiloWe,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            mulDone_c
);

  localparam int unsigned W2 = 2 * XLEN;

  // prod: product accumulator, upper half doubles as divide remainder.
  // mcand: shifted multiplicand, low half holds the divisor.
  // mplier: multiplier shifted right, or dividend/quotient shifted left.
  logic [W2-1:0]   prod;
  logic [W2-1:0]   mcand;
  logic [XLEN-1:0] mplier;
  logic            isDiv;
  logic            negLo;
  logic            negHi;
  logic            divZero;

  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] remSh;
  logic [XLEN-1:0] remSub;
  logic            take;
  logic [W2-1:0]   prodFix;
  logic [XLEN-1:0] quotFix;
  logic [XLEN-1:0] remFix;
  logic [XLEN-1:0] resHi;
  logic [XLEN-1:0] resLo;

  // Operand magnitudes, restoring-divide trial and sign-corrected results
  always_comb begin
    magA    = (isSignedOp(op) && srcA[XLEN-1]) ? -srcA : srcA;
    magB    = (isSignedOp(op) && srcB[XLEN-1]) ? -srcB : srcB;
    rem     = prod[W2-1:XLEN];
    remSh   = {rem[XLEN-2:0], mplier[XLEN-1]};
    take    = {rem[XLEN-1], remSh} >= {1'b0, mcand[XLEN-1:0]};
    remSub  = remSh - mcand[XLEN-1:0];
    prodFix = negLo ? -prod : prod;
    quotFix = divZero ? '1 : (negLo ? -mplier : mplier);
    remFix  = negHi ? -rem : rem;
    resHi   = isDiv ? remFix : prodFix[W2-1:XLEN];
    resLo   = isDiv ? quotFix : prodFix[XLEN-1:0];
  end

  // Load magnitudes and result signs, then advance one bit per step
  always_ff @(posedge clk) begin
    if (reset) begin
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
    end else if (load) begin
      isDiv   <= isDivOp(op);
      negLo   <= isSignedOp(op) && (srcA[XLEN-1] ^ srcB[XLEN-1]);
      negHi   <= isSignedOp(op) && srcA[XLEN-1];
      divZero <= (srcB == '0);
      prod    <= '0;
      if (isDivOp(op)) begin
        mcand  <= W2'(magB);
        mplier <= magA;
      end else begin
        mcand  <= W2'(magA);
        mplier <= magB;
      end
    end else if (step) begin
      if (isDiv) begin
        prod[W2-1:XLEN] <= take ? remSub : remSh;
        mplier          <= {mplier[XLEN-2:0], take};
      end else begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  // HI/LO: result lands on the fix cycle, otherwise MTHI/MTLO write srcA
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fix) begin
      hi <= resHi;
      lo <= resLo;
    end else begin
      if (hiloWe[1]) hi <= srcA;
      if (hiloWe[0]) lo <= srcA;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // The current step consumes the last set multiplier bit
  assign mulDone_c = !isDiv && (mplier[XLEN-1:1] == '0);
`else
  assign mulDone_c = 1'b0;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit and its HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies may leave RUN before XLEN iterations.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  muldiv_ctrl_if.slave  bus
);

  mdState_t         state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             fix;
  logic             busy;
  logic             mulDone_c;
  logic [1:0]       hiloWe;

  // Datapath strobes decoded from the state; a start suppresses a same-cycle HI/LO write
  always_comb begin
    busy   = (state != ST_IDLE);
    load   = (state == ST_IDLE) && bus.startE;
    step   = (state == ST_RUN);
    fix    = (state == ST_FIX);
    hiloWe = ((state == ST_IDLE) && !bus.startE) ? bus.hiloweE : 2'b00;
  end

  assign bus.busy     = busy;
  assign bus.stall_md = busy && (bus.hiloreadD || bus.muldivD);

  // IDLE -> RUN for XLEN iterations (or until early out) -> FIX for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.startE) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if ((cnt == CNT_W'(XLEN - 1)) || mulDone_c) state <= ST_FIX;
        end
        ST_FIX:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hazard logic must hold off new operations and HI/LO writes while busy
  assert property (@(posedge clk) disable iff (reset) busy |-> !bus.startE);
  assert property (@(posedge clk) disable iff (reset) busy |-> (bus.hiloweE == 2'b00));

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .op        (bus.opE),
    .srcA      (bus.srcaE),
    .srcB      (bus.srcbE),
    .hiloWe    (hiloWe),
    .hi        (bus.hi),
    .lo        (bus.lo),
    .mulDone_c (mulDone_c)
  );

endmodule
